// File: rtl/aes_gf_pkg.sv
// Shared constants and types for the AES GF(2^8) arithmetic blocks.
package aes_gf_pkg;

  // Low byte of x^8+x^4+x^3+x+1; bit 8 is implied.
  localparam logic [7:0] AES_POLY_LOW  = 8'h1B;
  localparam logic [7:0] GF_ONE        = 8'h01;
  // Seven square/multiply pairs, steps 0..6.
  localparam logic [2:0] INV_LAST_STEP = 3'd6;

  typedef enum logic [1:0] {
    IDLE,
    SQ,
    MUL,
    DONE
  } inv_state_e;

endpackage

// File: rtl/gf_mul8.sv
// Combinational GF(2^8) multiplier: carry-less product reduced modulo {1, POLY_LOW}.
module gf_mul8
  import aes_gf_pkg::*;
#(
  parameter logic [7:0] POLY_LOW = AES_POLY_LOW
) (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] p_o
);

  logic [7:0] a_sh;

  // Shift-and-add with reduction folded into each shift (xtime).
  always_comb begin
    p_o  = 8'h00;
    a_sh = a_i;
    for (int i = 0; i < 8; i++) begin
      if (b_i[i]) begin
        p_o = p_o ^ a_sh;
      end
      a_sh = {a_sh[6:0], 1'b0} ^ (a_sh[7] ? POLY_LOW : 8'h00);
    end
  end

endmodule

// File: rtl/gf_inverse_iterative.sv
// GF(2^8) multiplicative inverse via x^254 square-and-multiply on one shared multiplier.
// Not pipelined: one byte in flight, 14 compute cycles, ready/valid on both sides.
module gf_inverse_iterative
  import aes_gf_pkg::*;
#(
  parameter logic [7:0]  POLY_LOW = AES_POLY_LOW,
  parameter int unsigned DATA_W   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              input_valid,
  output logic              input_ready,
  input  logic [DATA_W-1:0] input_data,
  output logic              output_valid,
  input  logic              output_ready,
  output logic [DATA_W-1:0] output_data
);

  inv_state_e state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] sq_q, sq_d;
  logic [2:0] step_q, step_d;
  logic [7:0] out_q, out_d;

  logic [7:0] mul_a, mul_b, mul_p;

  gf_mul8 #(
    .POLY_LOW(POLY_LOW)
  ) u_mul (
    .a_i(mul_a),
    .b_i(mul_b),
    .p_o(mul_p)
  );

  // Next-state, operand selection and datapath updates.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sq_d    = sq_q;
    step_d  = step_q;
    out_d   = out_q;
    mul_a   = acc_q;
    mul_b   = sq_q;
    unique case (state_q)
      IDLE: begin
        if (input_valid) begin
          sq_d    = input_data;
          acc_d   = GF_ONE;
          step_d  = 3'd0;
          state_d = SQ;
        end
      end
      SQ: begin
        mul_a   = sq_q;
        sq_d    = mul_p;
        state_d = MUL;
      end
      MUL: begin
        acc_d = mul_p;
        if (step_q == INV_LAST_STEP) begin
          // Separate output register keeps output_data stable after the handshake.
          out_d   = mul_p;
          state_d = DONE;
        end else begin
          step_d  = step_q + 3'd1;
          state_d = SQ;
        end
      end
      DONE: begin
        if (output_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= 8'h00;
      sq_q    <= 8'h00;
      step_q  <= 3'd0;
      out_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sq_q    <= sq_d;
      step_q  <= step_d;
      out_q   <= out_d;
    end
  end

  assign input_ready  = (state_q == IDLE);
  assign output_valid = (state_q == DONE);
  assign output_data  = out_q;

endmodule
